cache_2way_param: RTL and testbench

CACHE_2WAY_PARAM -- requirements
Module: cache_2way_param

---
 rtl/cache_2way_param_if.sv | 32 +++
 rtl/cache_2way_param.sv | 140 ++++++++++++++
 tb/tb_cache_2way_param.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cache_2way_param_if.sv
// ----------------------------------------------------------------------------
// cache_2way_param_if : processor-side and memory-side bus of the 2-way cache
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface cache_2way_param_if;
   logic         proc_read;
   logic         proc_write;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_wdata;
   logic [31:0]  proc_rdata;
   logic         proc_stall;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;

   modport slave (
      input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
      output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
      input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

`default_nettype wire

// File: rtl/cache_2way_param.sv
// ----------------------------------------------------------------------------
// cache_2way_param : 2-way set-associative, 4-word-block, write-back cache
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cache_2way_param #(
   parameter int SET_BITS  = 2,
   parameter bit READ_ONLY = 1'b0
) (
   input  wire logic          clk,
   input  wire logic          proc_reset,
   cache_2way_param_if.slave  bus
);
   localparam int SETS  = 1 << SET_BITS;
   localparam int TAG_W = 28 - SET_BITS;

   typedef enum logic [1:0] {
      S_COMPARE   = 2'd0,
      S_WRITEBACK = 2'd1,
      S_ALLOCATE  = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_victim;
   logic [1:0][SETS-1:0]  r_valid;
   logic [1:0][SETS-1:0]  r_dirty;
   logic [SETS-1:0]       r_lru;
   logic [127:0]          r_data [2][SETS];
   logic [TAG_W-1:0]      r_tag  [2][SETS];

   logic [SET_BITS-1:0]   w_index;
   logic [TAG_W-1:0]      w_tag;
   logic [1:0]            w_word;
   logic                  w_wr, w_rd, w_req;
   logic                  w_hit0, w_hit1, w_hit, w_hit_way;
   logic                  w_victim_sel, w_victim_dirty;
   logic [127:0]          w_hit_block;
   logic                  w_compare;

   assign w_index   = bus.proc_addr[SET_BITS+1:2];
   assign w_tag     = bus.proc_addr[29:SET_BITS+2];
   assign w_word    = bus.proc_addr[1:0];
   assign w_wr      = bus.proc_write & ~READ_ONLY;
   assign w_rd      = bus.proc_read & ~w_wr;
   assign w_req     = w_wr | bus.proc_read;

   assign w_hit0    = r_valid[0][w_index] && (r_tag[0][w_index] == w_tag);
   assign w_hit1    = r_valid[1][w_index] && (r_tag[1][w_index] == w_tag);
   assign w_hit     = w_hit0 | w_hit1;
   assign w_hit_way = ~w_hit0;
   assign w_hit_block = r_data[w_hit_way][w_index];

   assign w_victim_sel   = !r_valid[0][w_index] ? 1'b0 :
                           !r_valid[1][w_index] ? 1'b1 : r_lru[w_index];
   assign w_victim_dirty = r_valid[w_victim_sel][w_index] & r_dirty[w_victim_sel][w_index];

   // Reset masks an in-flight memory transaction on the outputs immediately
   assign w_compare = (r_state == S_COMPARE) || proc_reset;

   always_comb begin
      bus.proc_stall = 1'b1;
      bus.proc_rdata = 32'd0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_addr   = 28'd0;
      bus.mem_wdata  = 128'd0;
      if (w_compare) begin
         bus.proc_stall = w_req & ~w_hit;
         if (w_rd && w_hit && !proc_reset)
            bus.proc_rdata = w_hit_block[{w_word, 5'b0} +: 32];
      end else begin
         case (r_state)
            S_WRITEBACK: begin
               if (!READ_ONLY) begin
                  bus.mem_write = 1'b1;
                  bus.mem_addr  = {r_tag[r_victim][w_index], w_index};
                  bus.mem_wdata = r_data[r_victim][w_index];
               end
            end
            S_ALLOCATE: begin
               bus.mem_read = 1'b1;
               bus.mem_addr = bus.proc_addr[29:2];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (proc_reset) begin
         r_state  <= S_COMPARE;
         r_victim <= 1'b0;
         r_valid  <= '0;
         r_dirty  <= '0;
         r_lru    <= '0;
      end else begin
         case (r_state)
            S_COMPARE: begin
               if (w_req && !w_hit) begin
                  r_victim <= w_victim_sel;
                  r_state  <= (!READ_ONLY && w_victim_dirty) ? S_WRITEBACK : S_ALLOCATE;
               end else if (w_req) begin
                  r_lru[w_index] <= ~w_hit_way;
                  if (w_wr)
                     r_dirty[w_hit_way][w_index] <= 1'b1;
               end
            end
            S_WRITEBACK: begin
               if (bus.mem_ready) begin
                  r_dirty[r_victim][w_index] <= 1'b0;
                  r_state <= S_ALLOCATE;
               end
            end
            S_ALLOCATE: begin
               if (bus.mem_ready) begin
                  r_valid[r_victim][w_index] <= 1'b1;
                  r_dirty[r_victim][w_index] <= 1'b0;
                  r_state <= S_COMPARE;
               end
            end
            default: r_state <= S_COMPARE;
         endcase
      end
   end

   // Data and tag storage carry no reset; validity alone qualifies them
   always_ff @(posedge clk) begin
      if (!proc_reset) begin
         if (r_state == S_ALLOCATE && bus.mem_ready) begin
            r_data[r_victim][w_index] <= bus.mem_rdata;
            r_tag[r_victim][w_index]  <= w_tag;
         end else if (r_state == S_COMPARE && w_wr && w_hit) begin
            r_data[w_hit_way][w_index][{w_word, 5'b0} +: 32] <= bus.proc_wdata;
         end
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_cache_2way_param.sv
// ----------------------------------------------------------------------------
// tb_cache_2way_param : directed vector bench for the 2-way cache (RW and RO)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cache_2way_param;
   logic clk = 1'b0;
   logic rst_a, rst_r;
   always #5 clk = ~clk;

   cache_2way_param_if b ();
   cache_2way_param_if r ();

   cache_2way_param #(.SET_BITS(2), .READ_ONLY(1'b0)) u_rw (.clk(clk), .proc_reset(rst_a), .bus(b));
   cache_2way_param #(.SET_BITS(2), .READ_ONLY(1'b1)) u_ro (.clk(clk), .proc_reset(rst_r), .bus(r));

   localparam logic [127:0] FA = {32'h000000A3, 32'h000000A2, 32'hA5A5A5A5, 32'h000000A0};
   localparam logic [127:0] FB = {32'h000000B3, 32'h000000B2, 32'hB1B1B1B1, 32'h000000B0};
   localparam logic [127:0] FC = {32'h000000C3, 32'h000000C2, 32'hC1C1C1C1, 32'h000000C0};

   int errors = 0;
   int checks = 0;
   bit ro_mwr_seen = 1'b0;

   logic         s_stall, s_mrd, s_mwr;
   logic [31:0]  s_rdata;
   logic [27:0]  s_maddr;
   logic [127:0] s_mwdata;

   always @(posedge clk) if (r.mem_write !== 1'b0 || r.mem_wdata !== 128'd0) ro_mwr_seen <= 1'b1;

   typedef struct {
      logic         rst, rd, wr;
      logic [29:0]  addr;
      logic [31:0]  wd;
      logic         rdy;
      logic [127:0] mdata;
      logic         e_stall;
      logic [31:0]  e_rdata;
      logic         e_mrd, e_mwr;
      logic [27:0]  e_maddr;
   } vec_t;

   vec_t tbl [20];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input bit ro, input logic rst, input logic rd, input logic wr,
                      input logic [29:0] addr, input logic [31:0] wd,
                      input logic rdy, input logic [127:0] mdata);
      @(negedge clk);
      if (ro) begin
         rst_r = rst; r.proc_read = rd; r.proc_write = wr; r.proc_addr = addr;
         r.proc_wdata = wd; r.mem_ready = rdy; r.mem_rdata = mdata;
      end else begin
         rst_a = rst; b.proc_read = rd; b.proc_write = wr; b.proc_addr = addr;
         b.proc_wdata = wd; b.mem_ready = rdy; b.mem_rdata = mdata;
      end
      #1;
      s_stall  = ro ? r.proc_stall : b.proc_stall;
      s_rdata  = ro ? r.proc_rdata : b.proc_rdata;
      s_mrd    = ro ? r.mem_read   : b.mem_read;
      s_mwr    = ro ? r.mem_write  : b.mem_write;
      s_maddr  = ro ? r.mem_addr   : b.mem_addr;
      s_mwdata = ro ? r.mem_wdata  : b.mem_wdata;
   endtask

   initial begin
      rst_a = 1'b1; rst_r = 1'b1;
      b.proc_read = 0; b.proc_write = 0; b.proc_addr = '0; b.proc_wdata = '0;
      b.mem_ready = 0; b.mem_rdata = '0;
      r.proc_read = 0; r.proc_write = 0; r.proc_addr = '0; r.proc_wdata = '0;
      r.mem_ready = 0; r.mem_rdata = '0;

      //            rst rd wr addr     wd rdy mdata   stall rdata          mrd mwr maddr
      tbl[0]  = '{1'b1,0,0,30'h000,32'd0,0,128'd0, 0,32'd0,          0,0,28'h00};
      tbl[1]  = '{1'b0,0,0,30'h000,32'd0,0,128'd0, 0,32'd0,          0,0,28'h00};
      tbl[2]  = '{1'b0,1,0,30'h005,32'd0,0,128'd0, 1,32'd0,          0,0,28'h00};
      tbl[3]  = '{1'b0,1,0,30'h005,32'd0,0,128'd0, 1,32'd0,          1,0,28'h01};
      tbl[4]  = '{1'b0,1,0,30'h005,32'd0,1,FA,     1,32'd0,          1,0,28'h01};
      tbl[5]  = '{1'b0,1,0,30'h005,32'd0,0,128'd0, 0,32'hA5A5A5A5,   0,0,28'h00};
      tbl[6]  = '{1'b0,1,0,30'h045,32'd0,0,128'd0, 1,32'd0,          0,0,28'h00};
      tbl[7]  = '{1'b0,1,0,30'h045,32'd0,1,FB,     1,32'd0,          1,0,28'h11};
      tbl[8]  = '{1'b0,1,0,30'h045,32'd0,0,128'd0, 0,32'hB1B1B1B1,   0,0,28'h00};
      tbl[9]  = '{1'b0,1,0,30'h005,32'd0,0,128'd0, 0,32'hA5A5A5A5,   0,0,28'h00};
      tbl[10] = '{1'b0,1,0,30'h085,32'd0,0,128'd0, 1,32'd0,          0,0,28'h00};
      tbl[11] = '{1'b0,1,0,30'h085,32'd0,1,FC,     1,32'd0,          1,0,28'h21};
      tbl[12] = '{1'b0,1,0,30'h085,32'd0,0,128'd0, 0,32'hC1C1C1C1,   0,0,28'h00};
      tbl[13] = '{1'b0,1,0,30'h005,32'd0,0,128'd0, 0,32'hA5A5A5A5,   0,0,28'h00};
      tbl[14] = '{1'b0,1,0,30'h045,32'd0,0,128'd0, 1,32'd0,          0,0,28'h00};
      tbl[15] = '{1'b0,1,0,30'h045,32'd0,1,FB,     1,32'd0,          1,0,28'h11};
      tbl[16] = '{1'b0,1,0,30'h045,32'd0,0,128'd0, 0,32'hB1B1B1B1,   0,0,28'h00};
      tbl[17] = '{1'b0,1,0,30'h006,32'd0,0,128'd0, 0,32'h000000A2,   0,0,28'h00};
      tbl[18] = '{1'b0,0,0,30'h000,32'd0,1,FC,     0,32'd0,          0,0,28'h00};
      tbl[19] = '{1'b0,1,0,30'h005,32'd0,1,FC,     0,32'hA5A5A5A5,   0,0,28'h00};

      for (int i = 0; i < 20; i++) begin
         cyc(0, tbl[i].rst, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].rdy, tbl[i].mdata);
         chk($sformatf("v%0d stall", i), s_stall, tbl[i].e_stall);
         chk($sformatf("v%0d rdata", i), s_rdata, tbl[i].e_rdata);
         chk($sformatf("v%0d mem_read", i), s_mrd, tbl[i].e_mrd);
         chk($sformatf("v%0d mem_write", i), s_mwr, tbl[i].e_mwr);
         chk($sformatf("v%0d mem_addr", i), s_maddr, tbl[i].e_maddr);
      end

      // Dirty eviction, read+write priority, write-allocate
      cyc(0, 1, 0, 0, 30'h000, 0, 0, 0);
      cyc(0, 0, 1, 0, 30'h005, 0, 0, 0);        chk("d cold stall", s_stall, 1);
      cyc(0, 0, 1, 0, 30'h005, 0, 1, FA);       chk("d fill mrd", s_mrd, 1);
      cyc(0, 0, 1, 0, 30'h005, 0, 0, 0);        chk("d hit rdata", s_rdata, 32'hA5A5A5A5);
      cyc(0, 0, 1, 1, 30'h005, 32'h12345678, 0, 0); chk("d rw hit stall", s_stall, 0);
      cyc(0, 0, 1, 0, 30'h005, 0, 0, 0);        chk("d rw readback", s_rdata, 32'h12345678);
      cyc(0, 0, 1, 0, 30'h045, 0, 0, 0);
      cyc(0, 0, 1, 0, 30'h045, 0, 1, FB);
      cyc(0, 0, 1, 0, 30'h045, 0, 0, 0);        chk("d 045 rdata", s_rdata, 32'hB1B1B1B1);
      cyc(0, 0, 1, 0, 30'h085, 0, 0, 0);        chk("d 085 miss stall", s_stall, 1);
      chk("d 085 compare mwr", s_mwr, 0);
      cyc(0, 0, 1, 0, 30'h085, 0, 0, 0);        chk("d wb mwr", s_mwr, 1);
      chk("d wb maddr", s_maddr, 28'h1);
      chk("d wb word1", s_mwdata[63:32], 32'h12345678);
      chk("d wb word0", s_mwdata[31:0], 32'hA0);
      chk("d wb mrd", s_mrd, 0);
      chk("d wb stall", s_stall, 1);
      cyc(0, 0, 1, 0, 30'h085, 0, 1, 0);        chk("d wb hold mwr", s_mwr, 1);
      cyc(0, 0, 1, 0, 30'h085, 0, 0, 0);        chk("d alloc mwr", s_mwr, 0);
      chk("d alloc mrd", s_mrd, 1);
      chk("d alloc maddr", s_maddr, 28'h21);
      chk("d alloc wdata", s_mwdata, 128'd0);
      cyc(0, 0, 1, 0, 30'h085, 0, 1, FC);
      cyc(0, 0, 1, 0, 30'h085, 0, 0, 0);        chk("d 085 rdata", s_rdata, 32'hC1C1C1C1);
      chk("d 085 stall", s_stall, 0);
      cyc(0, 0, 0, 1, 30'h009, 32'hDEADBEEF, 0, 0); chk("d wmiss stall", s_stall, 1);
      cyc(0, 0, 0, 1, 30'h009, 32'hDEADBEEF, 1, FA); chk("d wmiss maddr", s_maddr, 28'h2);
      cyc(0, 0, 0, 1, 30'h009, 32'hDEADBEEF, 0, 0); chk("d wmiss done stall", s_stall, 0);
      cyc(0, 0, 1, 0, 30'h009, 0, 0, 0);        chk("d wmiss readback", s_rdata, 32'hDEADBEEF);
      cyc(0, 0, 1, 0, 30'h00A, 0, 0, 0);        chk("d wmiss neighbour", s_rdata, 32'h000000A2);

      // Reset abandons an allocation; late mem_ready ignored
      cyc(0, 0, 1, 0, 30'h0C1, 0, 0, 0);        chk("r miss stall", s_stall, 1);
      cyc(0, 1, 1, 0, 30'h0C1, 0, 0, 0);        chk("r in-reset mrd", s_mrd, 0);
      chk("r in-reset maddr", s_maddr, 28'h0);
      cyc(0, 0, 0, 0, 30'h0C1, 0, 1, FB);       chk("r after stall", s_stall, 0);
      chk("r after mrd", s_mrd, 0);
      chk("r after rdata", s_rdata, 32'd0);
      cyc(0, 0, 1, 0, 30'h0C1, 0, 0, 0);        chk("r re-miss", s_stall, 1);
      cyc(0, 0, 1, 0, 30'h0C1, 0, 0, 0);        chk("r alloc maddr", s_maddr, 28'h30);
      cyc(0, 0, 1, 0, 30'h0C1, 0, 1, FB);
      cyc(0, 0, 1, 0, 30'h0C1, 0, 0, 0);        chk("r refill rdata", s_rdata, 32'hB1B1B1B1);
      cyc(0, 0, 1, 0, 30'h085, 0, 0, 0);        chk("r valid cleared", s_stall, 1);
      cyc(0, 0, 1, 0, 30'h085, 0, 1, FC);
      cyc(0, 0, 0, 0, 30'h000, 0, 0, 0);

      // Read-only instance
      cyc(1, 1, 0, 0, 30'h000, 0, 0, 0);        chk("ro reset stall", s_stall, 0);
      cyc(1, 0, 1, 0, 30'h005, 0, 0, 0);        chk("ro miss stall", s_stall, 1);
      cyc(1, 0, 1, 0, 30'h005, 0, 1, FA);       chk("ro alloc maddr", s_maddr, 28'h1);
      cyc(1, 0, 1, 0, 30'h005, 0, 0, 0);        chk("ro hit rdata", s_rdata, 32'hA5A5A5A5);
      cyc(1, 0, 0, 1, 30'h005, 32'h99, 0, 0);   chk("ro write stall", s_stall, 0);
      chk("ro write mwr", s_mwr, 0);
      cyc(1, 0, 1, 1, 30'h005, 32'h99, 0, 0);   chk("ro rw rdata", s_rdata, 32'hA5A5A5A5);
      cyc(1, 0, 1, 0, 30'h005, 0, 0, 0);        chk("ro unchanged", s_rdata, 32'hA5A5A5A5);
      cyc(1, 0, 1, 0, 30'h045, 0, 0, 0);
      cyc(1, 0, 1, 0, 30'h045, 0, 1, FB);
      cyc(1, 0, 1, 0, 30'h045, 0, 0, 0);        chk("ro 045 rdata", s_rdata, 32'hB1B1B1B1);
      cyc(1, 0, 1, 0, 30'h085, 0, 0, 0);        chk("ro 085 stall", s_stall, 1);
      cyc(1, 0, 1, 0, 30'h085, 0, 0, 0);        chk("ro no wb mrd", s_mrd, 1);
      chk("ro no wb maddr", s_maddr, 28'h21);
      chk("ro no wb mwr", s_mwr, 0);
      cyc(1, 0, 1, 0, 30'h085, 0, 1, FC);
      cyc(1, 0, 1, 0, 30'h085, 0, 0, 0);        chk("ro 085 rdata", s_rdata, 32'hC1C1C1C1);
      cyc(1, 0, 0, 0, 30'h000, 0, 0, 0);
      chk("ro mem_write never", ro_mwr_seen, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire
